// File: rtl/bus_if_types_pkg.sv
// Shared types for the master/slave data bus and the two-requester arbiter.
package bus_if_types_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int NUM_REQ = 2;

  // Transfer direction and size carried with every bus request.
  typedef enum logic {
    TT_READ  = 1'b0,
    TT_WRITE = 1'b1
  } ttype_e;

  typedef enum logic [1:0] {
    TS_BYTE = 2'd0,
    TS_HALF = 2'd1,
    TS_WORD = 2'd2
  } tsize_e;

  // Arbiter sequencing: idle, one-cycle downstream issue, wait for completion.
  typedef enum logic [1:0] {
    AIDLE  = 2'd0,
    AISSUE = 2'd1,
    AWAIT  = 2'd2
  } arb_state_e;

  // Requester index: the core port is requester 0, the debug module is 1.
  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_DM   = 1'b1
  } req_idx_e;

  // Fields captured at bstart and replayed on the shared bus.
  typedef struct packed {
    ttype_e              ttype;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    tsize_e              tsize;
  } bus_req_t;

  // Round-robin choice: on a tie the requester that was not granted last wins.
  function automatic req_idx_e rr_pick(input logic i_core_v, input logic i_dm_v,
                                       input req_idx_e i_last);
    req_idx_e w_pick;
    if (i_core_v && i_dm_v) begin
      if (i_last == REQ_CORE) w_pick = REQ_DM;
      else                    w_pick = REQ_CORE;
    end else if (i_dm_v) begin
      w_pick = REQ_DM;
    end else begin
      w_pick = REQ_CORE;
    end
    return w_pick;
  endfunction

endpackage

// File: rtl/master_bus_if.sv
// Simple start/done data bus: the master pulses bstart, the slave pulses bdone.
interface master_bus_if;

  logic                                 bstart;
  logic                                 breq;
  bus_if_types_pkg::ttype_e             ttype;
  logic [bus_if_types_pkg::ADDR_W-1:0]  addr;
  logic [bus_if_types_pkg::DATA_W-1:0]  wdata;
  bus_if_types_pkg::tsize_e             tsize;
  logic                                 bdone;
  logic [bus_if_types_pkg::DATA_W-1:0]  rdata;

  modport master (output bstart, breq, ttype, addr, wdata, tsize,
                  input  bdone, rdata);

  modport slave  (input  bstart, breq, ttype, addr, wdata, tsize,
                  output bdone, rdata);

endinterface

// File: rtl/bus_req_slot.sv
// One-deep pending slot for a single requester. A request arriving while the
// arbiter is idle is visible immediately (o_valid/o_req) so it can be granted
// in the same cycle without first landing in the slot.
module bus_req_slot
  import bus_if_types_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_bstart,
  input  logic     i_breq,
  input  bus_req_t i_req,
  input  logic     i_block,
  input  logic     i_grant,
  output logic     o_valid,
  output bus_req_t o_req
);

  logic     r_pending;
  bus_req_t r_req;
  logic     w_accept;

  // A pending or in-flight requester cannot stack a second request.
  assign w_accept = i_bstart & i_breq & ~r_pending & ~i_block;
  assign o_valid  = r_pending | w_accept;
  assign o_req    = r_pending ? r_req : i_req;

  // Slot storage: a grant consumes the slot (or the request arriving this cycle).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
      r_req     <= '0;
    end else if (i_grant) begin
      r_pending <= 1'b0;
    end else if (w_accept) begin
      r_pending <= 1'b1;
      r_req     <= i_req;
    end
  end

endmodule

// File: rtl/dbus_arbiter.sv
// Two-requester round-robin arbiter (core, debug module) onto one shared bus,
// with a downstream wait limit that force-completes a hung transaction.
module dbus_arbiter
  import bus_if_types_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
)
(
  input  logic         clk,
  input  logic         rst_n,
  master_bus_if.slave  core_bus,
  master_bus_if.slave  dm_bus,
  master_bus_if.master mem_bus,
  output logic         bus_timeout,
  output logic         owner
);

  localparam int              CNT_W       = 16;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  arb_state_e         r_state;
  arb_state_e         w_state_next;
  req_idx_e           r_owner;
  req_idx_e           r_last;
  req_idx_e           w_winner;
  bus_req_t           r_issue;
  logic [CNT_W-1:0]   r_wait;

  logic [NUM_REQ-1:0] w_bstart;
  logic [NUM_REQ-1:0] w_breq;
  logic [NUM_REQ-1:0] w_valid;
  logic [NUM_REQ-1:0] w_block;
  logic [NUM_REQ-1:0] w_grant;
  bus_req_t           w_req_in  [NUM_REQ];
  bus_req_t           w_req_sel [NUM_REQ];

  logic               w_busy;
  logic               w_timeout;
  logic               w_done;
  logic               w_start;

  assign w_bstart    = {dm_bus.bstart, core_bus.bstart};
  assign w_breq      = {dm_bus.breq, core_bus.breq};
  assign w_req_in[0] = '{ttype: core_bus.ttype, addr: core_bus.addr,
                         wdata: core_bus.wdata, tsize: core_bus.tsize};
  assign w_req_in[1] = '{ttype: dm_bus.ttype, addr: dm_bus.addr,
                         wdata: dm_bus.wdata, tsize: dm_bus.tsize};

  assign w_busy    = (r_state != AIDLE);
  // A real bdone in the limit cycle wins over the forced completion.
  assign w_timeout = w_busy & ~mem_bus.bdone & (r_wait == TIMEOUT_VAL);
  assign w_done    = w_busy & (mem_bus.bdone | w_timeout);
  assign w_start   = (r_state == AIDLE) & (|w_valid);
  assign w_winner  = rr_pick(w_valid[0], w_valid[1], r_last);

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
    // The owner may re-request in the cycle its own completion is delivered.
    assign w_block[gi] = w_busy & (r_owner == req_idx_e'(gi)) & ~w_done;
    assign w_grant[gi] = w_start & (w_winner == req_idx_e'(gi));

    bus_req_slot u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_bstart (w_bstart[gi]),
      .i_breq   (w_breq[gi]),
      .i_req    (w_req_in[gi]),
      .i_block  (w_block[gi]),
      .i_grant  (w_grant[gi]),
      .o_valid  (w_valid[gi]),
      .o_req    (w_req_sel[gi])
    );
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= AIDLE;
    else        r_state <= w_state_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      AIDLE:   if (w_start) w_state_next = AISSUE;
      AISSUE:  begin
        if (w_done) w_state_next = AIDLE;
        else        w_state_next = AWAIT;
      end
      AWAIT:   if (w_done) w_state_next = AIDLE;
      default: w_state_next = AIDLE;
    endcase
  end

  // FSM outputs: downstream drive from registered fields, completion routed to the owner.
  always_comb begin
    mem_bus.bstart = (r_state == AISSUE);
    mem_bus.breq   = (r_state == AISSUE);
    mem_bus.ttype  = r_issue.ttype;
    mem_bus.addr   = r_issue.addr;
    mem_bus.wdata  = r_issue.wdata;
    mem_bus.tsize  = r_issue.tsize;

    core_bus.bdone = w_done && (r_owner == REQ_CORE);
    core_bus.rdata = (w_done && (r_owner == REQ_CORE) && !w_timeout) ? mem_bus.rdata : '0;
    dm_bus.bdone   = w_done && (r_owner == REQ_DM);
    dm_bus.rdata   = (w_done && (r_owner == REQ_DM) && !w_timeout) ? mem_bus.rdata : '0;

    bus_timeout    = w_timeout;
    owner          = w_busy && (r_owner == REQ_DM);
  end

  // Grant bookkeeping: latch winner, its fields, and the round-robin history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= REQ_CORE;
      r_last  <= REQ_DM;
      r_issue <= '0;
    end else if (w_start) begin
      r_owner <= w_winner;
      r_last  <= w_winner;
      r_issue <= (w_winner == REQ_DM) ? w_req_sel[1] : w_req_sel[0];
    end
  end

  // Wait counter: zero at issue, counts every busy cycle without completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait <= '0;
    end else if (w_start) begin
      r_wait <= '0;
    end else if (w_busy && !w_done) begin
      r_wait <= r_wait + CNT_W'(1);
    end
  end

endmodule
